// File: rtl/tone_sequencer_if.sv
// Control/status bundle between the top-level pins and the tone sequencer.
// The master side drives playback controls, the slave side returns the DAC duty and status.
interface tone_sequencer_if #(
    parameter int unsigned N = 8
) ();
    logic         start;
    logic         stop;
    logic         loop_en;
    logic [N-1:0] volume;
    logic [N-1:0] t_on;
    logic         busy;
    logic [2:0]   note_idx;
    logic         done;

    modport master (
        output start, stop, loop_en, volume,
        input  t_on, busy, note_idx, done
    );

    modport slave (
        input  start, stop, loop_en, volume,
        output t_on, busy, note_idx, done
    );
endinterface

// File: rtl/tone_sequencer.sv
// Plays a fixed 8-note square-wave melody into the PWM DAC duty input.
// Duty only changes right after a PWM frame boundary, except on stop.
module tone_sequencer #(
    parameter int unsigned N         = 8,
    parameter int unsigned DUR_SHIFT = 4
) (
    input logic             clk,
    input logic             reset,
    tone_sequencer_if.slave bus
);
    localparam int unsigned DW = 6 + DUR_SHIFT;

    typedef enum logic [1:0] {StIdle, StArm, StPlay} state_e;

    function automatic logic [3:0] note_p(input logic [2:0] i);
        case (i)
            3'd0, 3'd1: note_p = 4'd4;
            3'd2:       note_p = 4'd3;
            3'd3:       note_p = 4'd0;
            3'd4:       note_p = 4'd5;
            3'd5:       note_p = 4'd2;
            3'd6:       note_p = 4'd6;
            default:    note_p = 4'd1;
        endcase
    endfunction

    function automatic logic [5:0] note_d(input logic [2:0] i);
        case (i)
            3'd0, 3'd1, 3'd2, 3'd6: note_d = 6'd16;
            3'd4:                   note_d = 6'd32;
            default:                note_d = 6'd8;
        endcase
    endfunction

    state_e        state_q, state_d;
    logic [N-1:0]  fcnt_q;
    logic [2:0]    idx_q, idx_d;
    logic          phase_q, phase_d;
    logic [3:0]    hcnt_q, hcnt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [N-1:0]  t_on_q, t_on_d;
    logic          done_q, done_d;

    logic          frame_end;
    logic          do_load;
    logic [2:0]    load_idx;
    logic          phase_new;
    logic [3:0]    p_cur;

    // Shares the DAC's reset, so both counters stay frame-aligned.
    assign frame_end = (fcnt_q == {N{1'b1}});
    assign p_cur     = note_p(idx_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        phase_d   = phase_q;
        hcnt_d    = hcnt_q;
        dcnt_d    = dcnt_q;
        t_on_d    = t_on_q;
        done_d    = 1'b0;
        do_load   = 1'b0;
        load_idx  = 3'd0;
        phase_new = phase_q;

        if (bus.stop) begin
            state_d = StIdle;
            t_on_d  = '0;
            idx_d   = 3'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    t_on_d = '0;
                    if (bus.start) begin
                        state_d = StArm;
                        idx_d   = 3'd0;
                    end
                end
                StArm: begin
                    if (frame_end) begin
                        do_load = 1'b1;
                        state_d = StPlay;
                    end
                end
                StPlay: begin
                    if (frame_end) begin
                        if (dcnt_q == '0) begin
                            if (idx_q != 3'd7) begin
                                do_load  = 1'b1;
                                load_idx = idx_q + 3'd1;
                            end else if (bus.loop_en) begin
                                do_load = 1'b1;
                            end else begin
                                state_d = StIdle;
                                t_on_d  = '0;
                                done_d  = 1'b1;
                                idx_d   = 3'd0;
                            end
                        end else begin
                            dcnt_d = dcnt_q - DW'(1);
                            if (hcnt_q == 4'd0) begin
                                phase_new = ~phase_q;
                                hcnt_d    = p_cur - 4'd1;
                            end else begin
                                hcnt_d = hcnt_q - 4'd1;
                            end
                            phase_d = phase_new;
                            t_on_d  = (p_cur != 4'd0 && phase_new) ? bus.volume : '0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // A rest (P=0) wraps hcnt to 15, harmless because its duty is forced to zero.
        if (do_load) begin
            idx_d   = load_idx;
            phase_d = 1'b1;
            hcnt_d  = note_p(load_idx) - 4'd1;
            dcnt_d  = (DW'(note_d(load_idx)) << DUR_SHIFT) - DW'(1);
            t_on_d  = (note_p(load_idx) != 4'd0) ? bus.volume : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            fcnt_q  <= '0;
            idx_q   <= 3'd0;
            phase_q <= 1'b0;
            hcnt_q  <= 4'd0;
            dcnt_q  <= '0;
            t_on_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_q + N'(1);
            idx_q   <= idx_d;
            phase_q <= phase_d;
            hcnt_q  <= hcnt_d;
            dcnt_q  <= dcnt_d;
            t_on_q  <= t_on_d;
            done_q  <= done_d;
        end
    end

    assign bus.t_on     = t_on_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.note_idx = idx_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// Randomized bench for tone_sequencer: a positional melody model predicts every output each cycle.
// The model maps "frames since ARM exit" onto the note table with plain arithmetic.
module tb_tone_sequencer;
    localparam int unsigned N     = 4;
    localparam int unsigned DS    = 0;
    localparam int          FRAME = 1 << N;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tone_sequencer_if #(.N(N)) bus ();

    tone_sequencer #(.N(N), .DUR_SHIFT(DS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int p_tab [8] = '{4, 4, 3, 0, 5, 2, 6, 1};
    int d_tab [8] = '{16, 16, 16, 8, 32, 8, 16, 8};

    typedef struct {
        int mode;  // 0 idle, 1 armed, 2 playing
        int cyc;   // clock position inside the current PWM frame
        int pos;   // frame number inside the melody pass
        int ton;
        int note;
        int done;
    } mstate_t;

    mstate_t m = '{default: 0};
    int      n_checks = 0;
    int      n_errors = 0;
    bit      chk_en   = 1'b0;

    function automatic int total_frames();
        int t = 0;
        for (int i = 0; i < 8; i++) t += d_tab[i] << DS;
        return t;
    endfunction

    function automatic void note_at(input int pos, input int vol, output int note, output int ton);
        int rem = pos;
        note = 0;
        ton  = 0;
        for (int i = 0; i < 8; i++) begin
            int len = d_tab[i] << DS;
            if (rem < len) begin
                note = i;
                ton  = (p_tab[i] != 0 && ((rem / p_tab[i]) % 2) == 0) ? vol : 0;
                return;
            end
            rem -= len;
        end
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input logic rst, input logic st,
                                           input logic sp, input logic le, input int vol);
        mstate_t n = s;
        bit fe;
        n.done = 0;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        fe    = (s.cyc == FRAME - 1);
        n.cyc = (s.cyc + 1) % FRAME;
        if (sp) begin
            n.mode = 0;
            n.ton  = 0;
            n.note = 0;
            return n;
        end
        case (s.mode)
            0: if (st) begin
                n.mode = 1;
                n.note = 0;
            end
            1: if (fe) begin
                n.mode = 2;
                n.pos  = 0;
                note_at(n.pos, vol, n.note, n.ton);
            end
            default: if (fe) begin
                n.pos = s.pos + 1;
                if (n.pos == total_frames()) begin
                    if (le) n.pos = 0;
                    else begin
                        n.mode = 0;
                        n.ton  = 0;
                        n.note = 0;
                        n.done = 1;
                    end
                end
                if (n.mode == 2) note_at(n.pos, vol, n.note, n.ton);
            end
        endcase
        return n;
    endfunction

    always @(posedge clk)
        m <= model_step(m, reset, bus.start, bus.stop, bus.loop_en, int'(bus.volume));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("t_on", 32'(bus.t_on), 32'(m.ton));
            check("busy", 32'(bus.busy), 32'(m.mode != 0));
            check("note_idx", 32'(bus.note_idx), 32'(m.note));
            check("done", 32'(bus.done), 32'(m.done));
        end
    end

    // Per-mille probabilities for each random input event per cycle.
    task automatic drive_cycles(input int n, input int p_start, input int p_stop, input int p_vol,
                                input int p_loop, input int p_reset);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.start = ($urandom_range(999) < p_start);
            bus.stop  = ($urandom_range(999) < p_stop);
            reset     = ($urandom_range(999) < p_reset);
            if ($urandom_range(999) < p_vol) bus.volume = N'($urandom);
            if ($urandom_range(999) < p_loop) bus.loop_en = ~bus.loop_en;
        end
    endtask

    task automatic pulse(input logic st, input logic sp);
        @(negedge clk);
        bus.start = st;
        bus.stop  = sp;
        reset     = 1'b0;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.loop_en = 1'b0;
        bus.volume  = N'(12);
        reset       = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle with no start
        drive_cycles(100, 0, 0, 0, 0, 0);

        // Full melody at volume 12, with an ignored start during playback
        pulse(1'b1, 1'b0);
        drive_cycles(900, 0, 0, 0, 0, 0);
        pulse(1'b1, 1'b0);
        drive_cycles(1200, 0, 0, 0, 0, 0);

        // Looping with random mid-frame volume changes, then let the pass end
        bus.loop_en = 1'b1;
        pulse(1'b1, 1'b0);
        drive_cycles(2500, 0, 0, 20, 0, 0);
        bus.loop_en = 1'b0;
        drive_cycles(2200, 0, 0, 20, 0, 0);

        // Stop mid-frame inside entry 4, then start and stop together in idle
        bus.volume = N'(12);
        pulse(1'b1, 1'b0);
        drive_cycles(FRAME * 61 + 7, 0, 0, 0, 0, 0);
        pulse(1'b0, 1'b1);
        drive_cycles(50, 0, 0, 0, 0, 0);
        pulse(1'b1, 1'b1);
        drive_cycles(40, 0, 0, 0, 0, 0);

        // Reset during playback restarts everything, including the frame counter
        pulse(1'b1, 1'b0);
        drive_cycles(300, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        drive_cycles(100, 0, 0, 0, 0, 0);

        // Random mix of all controls
        drive_cycles(20000, 20, 2, 30, 5, 1);
        drive_cycles(FRAME * 2, 0, 0, 0, 0, 0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
